// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the fetch sequencer (fetch_ctrl and its boot loader).
package fetch_ctrl_pkg;

    localparam int unsigned FC_PC_WIDTH   = 32;
    localparam int unsigned FC_INST_WIDTH = 32;

    typedef enum logic [1:0] {
        FC_BOOT  = 2'b00,
        FC_RUN   = 2'b01,
        FC_STALL = 2'b10,
        FC_HALT  = 2'b11
    } fc_state_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_boot_loader.sv
// Boot loader: ld_valid/ld_ready handshake, word counter and IMEM write port.
// done pulses in the cycle the final boot word (ld_last or the last IMEM word) is accepted.
module fetch_boot_loader
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = FC_PC_WIDTH,
    parameter int unsigned INST_WIDTH = FC_INST_WIDTH,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  ld_valid,
    input  logic [INST_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  imem_wr_en,
    output logic [PC_WIDTH-1:0]   imem_wr_addr,
    output logic [INST_WIDTH-1:0] imem_wr_data,
    output logic                  done
);

    localparam int unsigned CNT_W = cnt_width(IMEM_DEPTH);

    logic [CNT_W-1:0] ld_cnt_q;
    logic             accept;
    logic             at_end;

    // Transfer decode; reset only gates the visible port, not the internal accept.
    assign accept       = en & ld_valid;
    assign at_end       = (ld_cnt_q == CNT_W'(IMEM_DEPTH - 1));
    assign done         = accept & (ld_last | at_end);
    assign ld_ready     = en & reset_n;
    assign imem_wr_en   = accept & reset_n;
    assign imem_wr_addr = (accept & reset_n) ? PC_WIDTH'({ld_cnt_q, 2'b00}) : '0;
    assign imem_wr_data = (accept & reset_n) ? ld_data : '0;

    // Word counter; holds at the last IMEM index so it never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_cnt_q <= '0;
        end else if (accept && !at_end) begin
            ld_cnt_q <= ld_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: boots IMEM, then drives PC/IF-ID controls for branches, stalls and halt.
// Optional performance counters are built when FETCH_CTRL_PERF_CNT_EN is defined.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = FC_PC_WIDTH,
    parameter int unsigned INST_WIDTH   = FC_INST_WIDTH,
    parameter int unsigned IMEM_DEPTH   = 256,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ld_valid,
    input  logic [INST_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    input  logic                  branch_taken,
    input  logic [PC_WIDTH-1:0]   branch_target,
    input  logic                  hazard,
    input  logic                  halt_req,
    output logic                  pc_sel,
    output logic [PC_WIDTH-1:0]   pc_imm,
    output logic                  pc_write,
    output logic                  IF_ID_write,
    output logic                  IF_flush,
    output logic                  imem_wr_en,
    output logic [PC_WIDTH-1:0]   imem_wr_addr,
    output logic [INST_WIDTH-1:0] imem_wr_data,
    output logic                  boot_done,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    localparam int unsigned      SC_W         = cnt_width(STALL_CYCLES);
    localparam logic [SC_W-1:0]  STALL_RELOAD = SC_W'(STALL_CYCLES - 1);

    fc_state_e             state_q, state_d;
    logic [SC_W-1:0]       stall_q, stall_d;
    logic                  boot_done_q;
    logic                  boot_fin;
    logic                  redirect;
    logic [PC_WIDTH-1:0]   imm;
    logic                  pcw;
    logic                  ifidw;
    logic                  flush;

    fetch_boot_loader #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_boot (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (state_q == FC_BOOT),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .done         (boot_fin)
    );

    // State, stall counter and boot-done flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FC_BOOT;
            stall_q     <= '0;
            boot_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if (boot_fin) begin
                boot_done_q <= 1'b1;
            end
        end
    end

    // Next state and same-cycle fetch controls; priority halt > branch > hazard in RUN.
    always_comb begin
        state_d  = state_q;
        stall_d  = stall_q;
        redirect = 1'b0;
        imm      = '0;
        pcw      = 1'b0;
        ifidw    = 1'b0;
        flush    = 1'b0;
        case (state_q)
            FC_BOOT: begin
                flush = 1'b1;
                if (boot_fin) begin
                    state_d = FC_RUN;
                end
            end
            FC_RUN: begin
                pcw   = 1'b1;
                ifidw = 1'b1;
                if (halt_req) begin
                    pcw     = 1'b0;
                    state_d = FC_HALT;
                end else if (branch_taken) begin
                    redirect = 1'b1;
                    imm      = branch_target;
                    flush    = 1'b1;
                end else if (hazard) begin
                    pcw     = 1'b0;
                    ifidw   = 1'b0;
                    stall_d = STALL_RELOAD;
                    if (STALL_RELOAD != '0) begin
                        state_d = FC_STALL;
                    end
                end
            end
            FC_STALL: begin
                if (branch_taken) begin
                    redirect = 1'b1;
                    imm      = branch_target;
                    flush    = 1'b1;
                    pcw      = 1'b1;
                    ifidw    = 1'b1;
                    stall_d  = '0;
                    state_d  = FC_RUN;
                end else if (hazard) begin
                    stall_d = STALL_RELOAD;
                end else begin
                    stall_d = stall_q - SC_W'(1);
                    if (stall_q == SC_W'(1)) begin
                        state_d = FC_RUN;
                    end
                end
            end
            FC_HALT: begin
                flush = 1'b1;
                if (!halt_req) begin
                    state_d = FC_RUN;
                end
            end
            default: begin
                state_d = FC_BOOT;
            end
        endcase
    end

    // Every control output reads zero while reset is held.
    assign pc_sel      = redirect & reset_n;
    assign pc_imm      = reset_n ? imm : '0;
    assign pc_write    = pcw & reset_n;
    assign IF_ID_write = ifidw & reset_n;
    assign IF_flush    = flush & reset_n;
    assign boot_done   = boot_done_q;

`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counts of frozen fetch cycles and branch redirects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == FC_RUN || state_q == FC_STALL) && !pcw && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'(1);
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, reset/boot-depth sequence, then random vs reference model.
module tb_fetch_ctrl;

    localparam int unsigned PW    = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SC    = 3;

    // expected control bits: {ld_ready, imem_wr_en, pc_sel, pc_write, IF_ID_write, IF_flush, boot_done}
    localparam logic [6:0] E_BOOT = 7'b1100010;
    localparam logic [6:0] E_RUN  = 7'b0001101;
    localparam logic [6:0] E_BR   = 7'b0011111;
    localparam logic [6:0] E_FRZ  = 7'b0000001;
    localparam logic [6:0] E_HREQ = 7'b0000101;
    localparam logic [6:0] E_HALT = 7'b0000011;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ld_valid;
    logic [IW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          hazard;
    logic          halt_req;
    logic          pc_sel;
    logic [PW-1:0] pc_imm;
    logic          pc_write;
    logic          IF_ID_write;
    logic          IF_flush;
    logic          imem_wr_en;
    logic [PW-1:0] imem_wr_addr;
    logic [IW-1:0] imem_wr_data;
    logic          boot_done;
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .PC_WIDTH     (PW),
        .INST_WIDTH   (IW),
        .IMEM_DEPTH   (DEPTH),
        .STALL_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .ld_ready      (ld_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hazard        (hazard),
        .halt_req      (halt_req),
        .pc_sel        (pc_sel),
        .pc_imm        (pc_imm),
        .pc_write      (pc_write),
        .IF_ID_write   (IF_ID_write),
        .IF_flush      (IF_flush),
        .imem_wr_en    (imem_wr_en),
        .imem_wr_addr  (imem_wr_addr),
        .imem_wr_data  (imem_wr_data),
        .boot_done     (boot_done),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    typedef struct {
        string       name;
        logic        v;
        logic [31:0] d;
        logic        last;
        logic        br;
        logic [31:0] tgt;
        logic        hz;
        logic        halt;
        logic [6:0]  e;
        logic [31:0] e_addr;
        logic [31:0] e_imm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input string n, input logic v, input logic [31:0] d, input logic last,
                                 input logic br, input logic [31:0] tgt, input logic hz, input logic halt,
                                 input logic [6:0] e, input logic [31:0] e_addr, input logic [31:0] e_imm);
        vec_t r;
        r.name = n; r.v = v; r.d = d; r.last = last; r.br = br; r.tgt = tgt;
        r.hz = hz; r.halt = halt; r.e = e; r.e_addr = e_addr; r.e_imm = e_imm;
        return r;
    endfunction

    function automatic logic [102:0] pack(input logic r, input logic w, input logic [31:0] a,
                                          input logic [31:0] dt, input logic s, input logic [31:0] im,
                                          input logic pw, input logic ifd, input logic fl, input logic dn);
        return {r, w, a, dt, s, im, pw, ifd, fl, dn};
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic last, input logic br,
                         input logic [31:0] tgt, input logic hz, input logic halt);
        ld_valid = v; ld_data = d; ld_last = last; branch_taken = br;
        branch_target = tgt; hazard = hz; halt_req = halt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [102:0] exp);
        logic [102:0] act;
        act = pack(ld_ready, imem_wr_en, imem_wr_addr, imem_wr_data, pc_sel, pc_imm,
                   pc_write, IF_ID_write, IF_flush, boot_done);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (rdy,wen,addr,data,sel,imm,pcw,ifid,flush,done)", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [102:0] exp_from(input vec_t t);
        return pack(t.e[6], t.e[5], t.e_addr, t.e[5] ? t.d : 32'h0, t.e[4], t.e_imm,
                    t.e[3], t.e[2], t.e[1], t.e[0]);
    endfunction

    // reference model: boot progress, halt flag, remaining frozen cycles, perf counts
    bit          m_booted;
    int unsigned m_words;
    bit          m_halted;
    int unsigned m_freeze;
    bit          m_done;
    int unsigned m_stall;
    int unsigned m_flush;

    task automatic model_reset();
        m_booted = 0; m_words = 0; m_halted = 0; m_freeze = 0; m_done = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_cycle(input logic v, input logic [31:0] d, input logic last, input logic br,
                               input logic [31:0] tgt, input logic hz, input logic halt);
        logic r, w, s, pw, ifd, fl;
        logic [31:0] a, dt, im;
        r = 0; w = 0; s = 0; pw = 0; ifd = 0; fl = 0; a = 0; dt = 0; im = 0;
        if (!m_booted) begin
            r = 1; fl = 1;
            if (v) begin w = 1; a = 32'(m_words * 4); dt = d; end
        end else if (m_halted) begin
            fl = 1;
        end else if (m_freeze > 0) begin
            if (br) begin s = 1; im = tgt; fl = 1; pw = 1; ifd = 1; end
        end else begin
            pw = 1; ifd = 1;
            if (halt) pw = 0;
            else if (br) begin s = 1; im = tgt; fl = 1; end
            else if (hz) begin pw = 0; ifd = 0; end
        end
        check_vec("rand_outputs", pack(r, w, a, dt, s, im, pw, ifd, fl, m_done));
`ifdef FETCH_CTRL_PERF_CNT_EN
        check32("rand_stall_cnt", stall_cnt, m_stall);
        check32("rand_flush_cnt", flush_cnt, m_flush);
`else
        check32("rand_stall_cnt", stall_cnt, 0);
        check32("rand_flush_cnt", flush_cnt, 0);
`endif
        if (!m_booted) begin
            if (v) begin
                m_words++;
                if (last || m_words == DEPTH) m_booted = 1;
            end
        end else if (m_halted) begin
            if (!halt) m_halted = 0;
        end else begin
            if (!pw) m_stall++;
            if (s) m_flush++;
            if (m_freeze > 0) begin
                if (br) m_freeze = 0;
                else if (hz) m_freeze = SC - 1;
                else m_freeze--;
            end else if (halt) begin
                m_halted = 1;
            end else if (!br && hz) begin
                m_freeze = SC - 1;
            end
        end
        m_done = m_booted;
    endtask

    initial begin
        logic halt_lvl;
        logic [31:0] rd;

        // directed sequence: boot, branch, stall, stall+branch, halt vs branch, stall reload
        tbl.push_back(mkv("boot_w0",     1, 32'h13,  0, 0, 0,      0, 0, E_BOOT, 32'h0, 0));
        tbl.push_back(mkv("boot_w1",     1, 32'h93,  0, 0, 0,      0, 0, E_BOOT, 32'h4, 0));
        tbl.push_back(mkv("boot_w2",     1, 32'h113, 1, 0, 0,      0, 0, E_BOOT, 32'h8, 0));
        tbl.push_back(mkv("run_idle",    0, 0,       0, 0, 0,      0, 0, E_RUN,  0, 0));
        tbl.push_back(mkv("ld_ignored",  1, 32'hdead,0, 0, 0,      0, 0, E_RUN,  0, 0));
        tbl.push_back(mkv("branch",      0, 0,       0, 1, 32'h40, 0, 0, E_BR,   0, 32'h40));
        tbl.push_back(mkv("after_br",    0, 0,       0, 0, 32'h40, 0, 0, E_RUN,  0, 0));
        tbl.push_back(mkv("hazard",      0, 0,       0, 0, 0,      1, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("stall_1",     0, 0,       0, 0, 0,      0, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("stall_2",     0, 0,       0, 0, 0,      0, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("resume",      0, 0,       0, 0, 0,      0, 0, E_RUN,  0, 0));
        tbl.push_back(mkv("hazard_b",    0, 0,       0, 0, 0,      1, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("stall_b1",    0, 0,       0, 0, 0,      0, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("stall_br",    0, 0,       0, 1, 32'h80, 0, 0, E_BR,   0, 32'h80));
        tbl.push_back(mkv("after_sbr",   0, 0,       0, 0, 0,      0, 0, E_RUN,  0, 0));
        tbl.push_back(mkv("halt_vs_br",  0, 0,       0, 1, 32'h44, 0, 1, E_HREQ, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mkv("halted",  0, 0,       0, 1, 32'h48, 1, 1, E_HALT, 0, 0));
        tbl.push_back(mkv("unhalt",      0, 0,       0, 0, 0,      0, 0, E_HALT, 0, 0));
        tbl.push_back(mkv("resumed",     0, 0,       0, 0, 0,      0, 0, E_RUN,  0, 0));
        tbl.push_back(mkv("hz_r",        0, 0,       0, 0, 0,      1, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("hz_r_st1",    0, 0,       0, 0, 0,      0, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("hz_reload",   0, 0,       0, 0, 0,      1, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("reload_st1",  0, 0,       0, 0, 0,      0, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("reload_st2",  0, 0,       0, 0, 0,      0, 0, E_FRZ,  0, 0));
        tbl.push_back(mkv("reload_done", 0, 0,       0, 0, 0,      0, 0, E_RUN,  0, 0));

        // reset state: all outputs zero even with inputs active
        reset_n = 1'b0;
        drive(1, 32'h13, 1, 1, 32'h40, 1, 1);
        #3;
        check_vec("reset_outputs", '0);
        step();
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].last, tbl[i].br, tbl[i].tgt, tbl[i].hz, tbl[i].halt);
            #4;
            check_vec(tbl[i].name, exp_from(tbl[i]));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #4;
`ifdef FETCH_CTRL_PERF_CNT_EN
        check32("table_stall_cnt", stall_cnt, 11);
        check32("table_flush_cnt", flush_cnt, 2);
`else
        check32("table_stall_cnt", stall_cnt, 0);
        check32("table_flush_cnt", flush_cnt, 0);
`endif
        step();

        // reset mid-boot after two words, then reboot to full IMEM depth without ld_last
        reset_n = 1'b0;
        #4;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h100 + 32'(i), 0, 0, 0, 0, 0);
            #4;
            check_vec("preboot_word", pack(1, 1, 32'(i * 4), 32'h100 + 32'(i), 0, 0, 0, 0, 1, 0));
            step();
        end
        drive(1, 32'h55, 0, 1, 32'h40, 1, 0);
        reset_n = 1'b0;
        #4;
        check_vec("midboot_reset", '0);
        check32("reset_stall_cnt", stall_cnt, 0);
        check32("reset_flush_cnt", flush_cnt, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1, 32'hA0 + 32'(i), 0, 0, 0, 0, 0);
            #4;
            check_vec("reboot_word", pack(1, 1, 32'(i * 4), 32'hA0 + 32'(i), 0, 0, 0, 0, 1, 0));
            step();
        end
        drive(1, 32'hBB, 0, 0, 0, 0, 0);
        #4;
        check_vec("depth_end_run", pack(0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        step();

        // randomized run against the reference model
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        reset_n = 1'b1;
        model_reset();
        halt_lvl = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            logic v, last, br, hz;
            logic [31:0] d, tgt;
            if ($urandom_range(15) == 0) halt_lvl = ~halt_lvl;
            v    = ($urandom_range(1) == 1);
            d    = $urandom;
            last = ($urandom_range(7) == 0);
            br   = ($urandom_range(6) == 0);
            rd   = $urandom;
            tgt  = {rd[31:2], 2'b00};
            hz   = ($urandom_range(4) == 0);
            drive(v, d, last, br, tgt, hz, halt_lvl);
            #4;
            model_cycle(v, d, last, br, tgt, hz, halt_lvl);
            step();
            if (c % 400 == 399) begin
                reset_n = 1'b0;
                drive(0, 0, 0, 0, 0, 0, 0);
                step();
                reset_n = 1'b1;
                model_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
